// File: rtl/disp_scan_ctrl.sv
// Eight-digit seven-segment scan controller: sweeps the digit code 0..7 with an
// anti-ghosting blank gap and double-buffered frame data.
//
// state | meaning
// IDLE  | scan stopped, code parked at 0, outputs blanked
// SHOW  | current digit driven for CLK_DIV cycles
// BLANK | gap of BLANK_CYCLES cycles, code already on the next digit
module disp_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  mask_in,
  output logic [2:0]  code,
  output logic        digit_valid,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        frame_done,
  output logic        pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [3:0]       nib_q, nib_d;
  logic             dp_q, dp_d;
  logic             fd_q, fd_d;
  logic             pend_q, pend_d;
  logic [31:0]      act_data_q, act_data_d, pnd_data_q, pnd_data_d;
  logic [7:0]       act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d;
  logic [7:0]       act_mask_q, act_mask_d, pnd_mask_q, pnd_mask_d;
  logic             wrap;
  logic             direct_load;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    code_d      = code_q;
    wrap        = 1'b0;
    pend_d      = pend_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_mask_d  = act_mask_q;
    pnd_data_d  = pnd_data_q;
    pnd_dp_d    = pnd_dp_q;
    pnd_mask_d  = pnd_mask_q;
    direct_load = load && ((state_q == IDLE) || !en);

    case (state_q)
      IDLE: begin
        presc_d = '0;
        code_d  = '0;
        if (en) state_d = SHOW;
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          presc_d = '0;
          code_d  = '0;
        end else if (presc_q == SHOW_LAST) begin
          presc_d = '0;
          code_d  = code_q + 3'd1;
          wrap    = (code_q == 3'd7);
          if (BLANK_CYCLES > 0) state_d = BLANK;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          presc_d = '0;
          code_d  = '0;
        end else if (presc_q == BLANK_LAST) begin
          presc_d = '0;
          state_d = SHOW;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        code_d  = '0;
      end
    endcase

    // Frame data only changes at a frame boundary while scanning; a stopped
    // scan takes loads straight into the active buffer.
    if (direct_load) begin
      act_data_d = data_in;
      act_dp_d   = dp_in;
      act_mask_d = mask_in;
      pend_d     = 1'b0;
    end else begin
      if ((wrap || ((state_q == IDLE) && en)) && pend_q) begin
        act_data_d = pnd_data_q;
        act_dp_d   = pnd_dp_q;
        act_mask_d = pnd_mask_q;
        pend_d     = 1'b0;
      end
      if (load) begin
        pnd_data_d = data_in;
        pnd_dp_d   = dp_in;
        pnd_mask_d = mask_in;
        pend_d     = 1'b1;
      end
    end

    fd_d    = wrap;
    valid_d = (state_d == SHOW) && act_mask_d[code_d];
    nib_d   = act_data_d[{code_d, 2'b00} +: 4];
    dp_d    = act_dp_d[code_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      nib_q      <= '0;
      dp_q       <= 1'b0;
      fd_q       <= 1'b0;
      pend_q     <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_mask_q <= '0;
      pnd_data_q <= '0;
      pnd_dp_q   <= '0;
      pnd_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      nib_q      <= nib_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
      pend_q     <= pend_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_mask_q <= act_mask_d;
      pnd_data_q <= pnd_data_d;
      pnd_dp_q   <= pnd_dp_d;
      pnd_mask_q <= pnd_mask_d;
    end
  end

  assign code        = code_q;
  assign digit_valid = valid_q;
  assign nibble      = nib_q;
  assign dp          = dp_q;
  assign frame_done  = fd_q;
  assign pending     = pend_q;

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Upstream driver for the 3-to-8 digit-select decoder on the 8-digit seven-segment display path.
- Time-multiplexes eight 4-bit digit values by sweeping a 3-bit digit code 0..7 at a divided rate.
- Inserts an anti-ghosting blank gap between digits.
- Double-buffers display data so a new frame never tears mid-sweep.
- Its code output feeds the decoder. Its nibble/dp outputs feed the segment encoder. digit_valid gates the decoded anodes.

Parameters:
CLK_DIV, 100000, clk cycles each digit is shown (SHOW dwell); legal range >= 1
BLANK_CYCLES, 4, clk cycles of blanking after each digit; 0 = no gap
CNT_W, 17, prescaler counter width; must satisfy 2**CNT_W > max(CLK_DIV, BLANK_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  scan enable; 0 forces IDLE
load  in  1  single-cycle strobe: capture data_in/dp_in/mask_in into the pending buffer
data_in  in  32  digit values; digit k = data_in[4k+3:4k]
dp_in  in  8  decimal point per digit
mask_in  in  8  per-digit enable; 0 = digit dark in its slot
code  out  3  current digit index, to the decoder
digit_valid  out  1  1 = drive current digit; 0 = blank (masked, blank gap, or idle)
nibble  out  4  active value of digit code
dp  out  1  active decimal point of digit code
frame_done  out  1  one-cycle pulse when code wraps 7->0
pending  out  1  1 = loaded data waiting for the frame boundary

Behaviour:
- Single clock domain. Reset is synchronous and active-high; rst wins over all other inputs.
- Reset values:
  - state=IDLE; code=0; digit_valid=0; nibble=0; dp=0; frame_done=0; pending=0.
  - Active and pending buffers, including masks, cleared to 0.
  - Prescaler cleared to 0.
- All outputs are registered.
- nibble/dp always equal the active buffer entry selected by the registered code, in the same cycle as code.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - code=0, valid=0, prescaler=0.
  - If en=1, next cycle goes to SHOW with code=0 and valid=active_mask[0].
- SHOW:
  - Prescaler counts 0..CLK_DIV-1; valid=active_mask[code].
  - At count CLK_DIV-1: prescaler<=0 and code<=code+1 (mod 8).
  - If BLANK_CYCLES>0, go to BLANK with valid=0.
  - If BLANK_CYCLES=0, stay in SHOW; valid takes the mask bit of the new code.
- BLANK:
  - valid=0 for exactly BLANK_CYCLES cycles; code already holds the next digit.
  - Then go to SHOW with valid=active_mask[code].
- Digit period is CLK_DIV+BLANK_CYCLES. Frame period is 8*(CLK_DIV+BLANK_CYCLES).
- Masked digits keep their full time slot, so brightness is uniform regardless of mask.
- Wrap: the cycle code goes 7->0 asserts frame_done for exactly one cycle.
  - If pending=1 on that cycle, pending copies into active and pending<=0.
  - The new values are visible with code=0.
- load:
  - In IDLE, or with en=0: data applies directly to active next cycle; pending stays 0.
  - Otherwise: capture into pending, pending<=1.
  - A load while pending=1 overwrites pending (last write wins).
  - load coincident with the wrap cycle: the wrap promotes the old pending contents. The new data is captured into pending and pending stays 1.
- en falls mid-scan: next cycle IDLE, code=0, valid=0, prescaler cleared, no frame_done. Pending contents are retained and promoted on the next en rise (applied before SHOW of digit 0).
- Reset mid-scan: immediate return to reset values. Pending data is lost.

Test Plan:
- Parameters CLK_DIV=4, BLANK_CYCLES=2. rst, then load data_in=32'h76543210, dp_in=8'h01, mask_in=8'hFF while en=0, then en=1 -> code steps 0..7, each digit valid=1 for 4 cycles then 0 for 2 cycles. nibble==code. dp=1 only at code 0. frame_done pulses every 48 cycles.
- Mid-frame at code=3, load data_in=32'hFFFFFFFF -> pending=1. Digits 3..7 still show 3..7. On the wrap, frame_done=1, pending=0, and code=0 shows nibble=F.
- mask_in=8'b1010_1010 -> valid stays 0 for even codes across their full 6-cycle slot. Odd codes show valid=1 for 4 cycles. Frame length stays 48.
- Assert load on the exact wrap cycle with another value pending -> old pending goes active at code=0, the new value sits in pending (pending=1), and it goes active at the next wrap.
- Drop en at code=5 mid-SHOW -> next cycle code=0, valid=0, no frame_done pulse. Re-raise en -> SHOW at code=0 with pending data applied.
- Parameters BLANK_CYCLES=0, CLK_DIV=1 -> code increments every cycle, valid follows the mask continuously, frame_done pulses every 8 cycles. rst asserted mid-sweep -> all outputs 0 next cycle.
